// File: rtl/frame_scheduler.sv
// Frame scheduler: sequences background clear, sprite queue and buffer swap
// against the VGA vertical sync, with a per-frame watchdog and overrun reporting.
module frame_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 1666666
) (
    input  logic       CLOCK_50,
    input  logic       RESET_L,
    input  logic       ENABLE,
    input  logic       VSYNC,
    input  logic [2:0] SPRITE_COUNT,
    input  logic       CLEAR_DONE,
    input  logic       QUEUE_DONE,
    output logic       RUN_CLEAR,
    output logic       RUN_QUEUE,
    output logic [2:0] STOP_ADDRESS,
    output logic       SWAP_BUF,
    output logic       DRAW_BUF,
    output logic       FRAME_BUSY,
    output logic [7:0] FRAME_COUNT,
    output logic       OVERRUN,
    output logic       TIMEOUT
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_VS   = 3'd1,
        S_CLEAR     = 3'd2,
        S_QUEUE     = 3'd3,
        S_WAIT_SWAP = 3'd4,
        S_SWAP      = 3'd5
    } state_t;

    localparam logic [20:0] WD_LIMIT = 21'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        vs_prev_q, vs_prev_d;
    logic [2:0]  stop_q, stop_d;
    logic        draw_buf_q, draw_buf_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [20:0] wd_q, wd_d;
    logic        overrun_q, overrun_d;
    logic        timeout_q, timeout_d;
    logic        vs_edge_s;
    logic        wd_expired_s;

    assign vs_edge_s    = vs_prev_q & ~VSYNC;
    // Greater-or-equal keeps the budget enforced in QUEUE even after the
    // count has passed the limit in a cycle where CLEAR_DONE won.
    assign wd_expired_s = (wd_q >= WD_LIMIT);

    // Next-state, latch and pulse computation for the frame sequence.
    always_comb begin
        state_d     = state_q;
        vs_prev_d   = VSYNC;
        stop_d      = stop_q;
        draw_buf_d  = draw_buf_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = 1'b0;
        timeout_d   = 1'b0;
        if ((state_q == S_CLEAR) || (state_q == S_QUEUE)) begin
            wd_d = wd_q + 21'd1;
        end else begin
            wd_d = wd_q;
        end

        case (state_q)
            S_IDLE: begin
                if (ENABLE) begin
                    state_d = S_WAIT_VS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_VS: begin
                if (vs_edge_s) begin
                    state_d = S_CLEAR;
                    stop_d  = SPRITE_COUNT;
                    wd_d    = 21'd0;
                end else if (!ENABLE) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_VS;
                end
            end
            S_CLEAR: begin
                overrun_d = vs_edge_s;
                if (CLEAR_DONE) begin
                    state_d = S_QUEUE;
                end else if (wd_expired_s) begin
                    state_d   = S_WAIT_VS;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            S_QUEUE: begin
                if (QUEUE_DONE && vs_edge_s) begin
                    state_d = S_SWAP;
                end else if (QUEUE_DONE) begin
                    state_d = S_WAIT_SWAP;
                end else if (wd_expired_s) begin
                    overrun_d = vs_edge_s;
                    state_d   = S_WAIT_VS;
                    timeout_d = 1'b1;
                end else begin
                    overrun_d = vs_edge_s;
                    state_d   = S_QUEUE;
                end
            end
            S_WAIT_SWAP: begin
                if (vs_edge_s) begin
                    state_d = S_SWAP;
                end else begin
                    state_d = S_WAIT_SWAP;
                end
            end
            S_SWAP: begin
                if (ENABLE) begin
                    state_d = S_CLEAR;
                    stop_d  = SPRITE_COUNT;
                    wd_d    = 21'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Buffer index and frame count advance on the way into SWAP.
        if (state_d == S_SWAP) begin
            draw_buf_d  = ~draw_buf_q;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            draw_buf_d  = draw_buf_q;
            frame_cnt_d = frame_cnt_q;
        end
    end

    // State and output registers; reset forces IDLE immediately.
    always_ff @(posedge CLOCK_50 or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q     <= S_IDLE;
            vs_prev_q   <= 1'b1;
            stop_q      <= 3'd0;
            draw_buf_q  <= 1'b0;
            frame_cnt_q <= 8'd0;
            wd_q        <= 21'd0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_prev_q   <= vs_prev_d;
            stop_q      <= stop_d;
            draw_buf_q  <= draw_buf_d;
            frame_cnt_q <= frame_cnt_d;
            wd_q        <= wd_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign RUN_CLEAR    = (state_q == S_CLEAR);
    assign RUN_QUEUE    = (state_q == S_QUEUE);
    assign SWAP_BUF     = (state_q == S_SWAP);
    assign FRAME_BUSY   = (state_q == S_CLEAR) || (state_q == S_QUEUE);
    assign STOP_ADDRESS = stop_q;
    assign DRAW_BUF     = draw_buf_q;
    assign FRAME_COUNT  = frame_cnt_q;
    assign OVERRUN      = overrun_q;
    assign TIMEOUT      = timeout_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: scenario tasks plus a swap scoreboard
// holding the expected {DRAW_BUF, FRAME_COUNT} of every frame swap.
module tb_frame_scheduler;

    logic       clk;
    logic       rst_l;
    logic       enable;
    logic       vsync;
    logic [2:0] sprite_count;
    logic       clear_done;
    logic       queue_done;
    logic       run_clear;
    logic       run_queue;
    logic [2:0] stop_address;
    logic       swap_buf;
    logic       draw_buf;
    logic       frame_busy;
    logic [7:0] frame_count;
    logic       overrun;
    logic       timeout;

    int passed = 0;
    int total  = 0;

    logic [8:0] swap_q[$];
    logic [7:0] exp_fc = 8'd0;
    logic       exp_db = 1'b0;

    frame_scheduler #(.TIMEOUT_CYCLES(16)) dut (
        .CLOCK_50     (clk),
        .RESET_L      (rst_l),
        .ENABLE       (enable),
        .VSYNC        (vsync),
        .SPRITE_COUNT (sprite_count),
        .CLEAR_DONE   (clear_done),
        .QUEUE_DONE   (queue_done),
        .RUN_CLEAR    (run_clear),
        .RUN_QUEUE    (run_queue),
        .STOP_ADDRESS (stop_address),
        .SWAP_BUF     (swap_buf),
        .DRAW_BUF     (draw_buf),
        .FRAME_BUSY   (frame_busy),
        .FRAME_COUNT  (frame_count),
        .OVERRUN      (overrun),
        .TIMEOUT      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 1ms");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_edge();
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
    endtask

    task automatic pulse_clear_done();
        clear_done = 1'b1;
        tick();
        clear_done = 1'b0;
    endtask

    task automatic pulse_queue_done();
        queue_done = 1'b1;
        tick();
        queue_done = 1'b0;
    endtask

    task automatic expect_swap();
        exp_fc = exp_fc + 8'd1;
        exp_db = ~exp_db;
        swap_q.push_back({exp_db, exp_fc});
    endtask

    // Waits (bounded) for SWAP_BUF, pops the scoreboard and compares, then
    // steps past the swap and confirms the pulse lasted one cycle.
    task automatic wait_swap(input string name);
        bit found = 1'b0;
        logic [8:0] exp_v;
        for (int i = 0; i < 8; i++) begin
            if (swap_buf === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        exp_v = (swap_q.size() > 0) ? swap_q.pop_front() : 9'h1FF;
        total++;
        if (!found) $display("FAIL %s_swap_seen: got no SWAP_BUF within 8 cycles, want a pulse", name);
        else if ({draw_buf, frame_count} !== exp_v)
            $display("FAIL %s_swap_state: got db/fc %b/%0d want %b/%0d", name, draw_buf, frame_count, exp_v[8], exp_v[7:0]);
        else passed++;
        tick();
        total++;
        if (swap_buf !== 1'b0) $display("FAIL %s_swap_width: got SWAP_BUF %b after one cycle want 0", name, swap_buf);
        else passed++;
    endtask

    task automatic test_reset();
        logic [17:0] obs;
        rst_l = 1'b1; enable = 1'b0; vsync = 1'b1; sprite_count = 3'd0;
        clear_done = 1'b0; queue_done = 1'b0;
        #1 rst_l = 1'b0;
        #2;
        obs = {run_clear, run_queue, swap_buf, frame_busy, overrun, timeout, draw_buf, stop_address, frame_count};
        total++;
        if (obs !== 18'd0) $display("FAIL reset_values: got %h want %h", obs, 18'd0);
        else passed++;
        tick(); tick();
        rst_l = 1'b1;
        tick(); tick();
        total++;
        if ({frame_busy, swap_buf, frame_count} !== 10'd0)
            $display("FAIL reset_idle_after_release: got %h want %h", {frame_busy, swap_buf, frame_count}, 10'd0);
        else passed++;
    endtask

    task automatic test_basic_frame();
        enable = 1'b1;
        tick();
        total++;
        if (frame_busy !== 1'b0) $display("FAIL basic_wait_vs_idle: got FRAME_BUSY %b want 0", frame_busy);
        else passed++;
        sprite_count = 3'd5;
        vs_edge();
        total++;
        if ({run_clear, run_queue, frame_busy} !== 3'b101)
            $display("FAIL basic_run_clear: got rc/rq/busy %b want 101", {run_clear, run_queue, frame_busy});
        else passed++;
        total++;
        if (stop_address !== 3'd5) $display("FAIL basic_stop_latch: got %0d want 5", stop_address);
        else passed++;
        sprite_count = 3'd2;
        tick();
        total++;
        if (stop_address !== 3'd5) $display("FAIL basic_stop_stable: got %0d want 5", stop_address);
        else passed++;
        pulse_clear_done();
        total++;
        if ({run_clear, run_queue} !== 2'b01) $display("FAIL basic_run_queue: got rc/rq %b want 01", {run_clear, run_queue});
        else passed++;
        pulse_queue_done();
        total++;
        if ({run_queue, frame_busy} !== 2'b00) $display("FAIL basic_queue_stop: got rq/busy %b want 00", {run_queue, frame_busy});
        else passed++;
        tick();
        total++;
        if (swap_buf !== 1'b0) $display("FAIL basic_no_early_swap: got %b want 0", swap_buf);
        else passed++;
        expect_swap();
        vs_edge();
        wait_swap("basic");
        total++;
        if ({run_clear, stop_address} !== {1'b1, 3'd2})
            $display("FAIL basic_next_frame: got rc/stop %b/%0d want 1/2", run_clear, stop_address);
        else passed++;
    endtask

    task automatic test_overrun();
        int extra_ov = 0;
        int early_sw = 0;
        pulse_clear_done();
        tick();
        vs_edge();
        total++;
        if ({overrun, run_queue} !== 2'b11) $display("FAIL overrun_pulse: got ov/rq %b want 11", {overrun, run_queue});
        else passed++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (overrun === 1'b1) extra_ov++;
            if (swap_buf === 1'b1) early_sw++;
        end
        total++;
        if (extra_ov != 0 || early_sw != 0)
            $display("FAIL overrun_single: got extra ov %0d swaps %0d want 0/0", extra_ov, early_sw);
        else passed++;
        pulse_queue_done();
        total++;
        if ({swap_buf, frame_count} !== {1'b0, exp_fc})
            $display("FAIL overrun_wait_swap: got sb/fc %b/%0d want 0/%0d", swap_buf, frame_count, exp_fc);
        else passed++;
        expect_swap();
        vs_edge();
        wait_swap("overrun");
    endtask

    task automatic test_same_cycle_swap();
        vs_edge();
        total++;
        if ({overrun, run_clear} !== 2'b11) $display("FAIL clear_overrun: got ov/rc %b want 11", {overrun, run_clear});
        else passed++;
        tick();
        pulse_clear_done();
        queue_done = 1'b1;
        vsync = 1'b0;
        expect_swap();
        tick();
        queue_done = 1'b0;
        vsync = 1'b1;
        total++;
        if ({swap_buf, overrun} !== 2'b10) $display("FAIL same_cycle_swap: got sb/ov %b want 10", {swap_buf, overrun});
        else passed++;
        wait_swap("same_cycle");
    endtask

    task automatic test_timeout();
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            if (run_clear !== 1'b1) break;
            n++;
            tick();
        end
        total++;
        if (n != 16 || timeout !== 1'b1)
            $display("FAIL timeout_fire: got %0d clear cycles TIMEOUT %b want 16 and 1", n, timeout);
        else passed++;
        total++;
        if ({draw_buf, frame_count} !== {exp_db, exp_fc})
            $display("FAIL timeout_no_swap: got db/fc %b/%0d want %b/%0d", draw_buf, frame_count, exp_db, exp_fc);
        else passed++;
        tick();
        total++;
        if ({timeout, frame_busy, swap_buf} !== 3'b000)
            $display("FAIL timeout_after: got to/busy/sb %b want 000", {timeout, frame_busy, swap_buf});
        else passed++;
        vs_edge();
        total++;
        if (run_clear !== 1'b1) $display("FAIL timeout_restart: got RUN_CLEAR %b want 1", run_clear);
        else passed++;
    endtask

    task automatic test_done_at_expiry();
        repeat (15) tick();
        pulse_clear_done();
        total++;
        if ({run_queue, timeout} !== 2'b10) $display("FAIL expiry_clear_done: got rq/to %b want 10", {run_queue, timeout});
        else passed++;
        pulse_queue_done();
        total++;
        if ({timeout, frame_busy} !== 2'b00) $display("FAIL expiry_queue_done: got to/busy %b want 00", {timeout, frame_busy});
        else passed++;
        expect_swap();
        vs_edge();
        wait_swap("expiry");
    endtask

    task automatic test_enable_drop();
        enable = 1'b0;
        tick();
        total++;
        if (run_clear !== 1'b1) $display("FAIL drop_no_abort: got RUN_CLEAR %b want 1", run_clear);
        else passed++;
        pulse_queue_done();
        total++;
        if ({run_clear, run_queue} !== 2'b10) $display("FAIL ignore_queue_done: got rc/rq %b want 10", {run_clear, run_queue});
        else passed++;
        pulse_clear_done();
        pulse_clear_done();
        total++;
        if ({run_clear, run_queue} !== 2'b01) $display("FAIL ignore_clear_done: got rc/rq %b want 01", {run_clear, run_queue});
        else passed++;
        pulse_queue_done();
        expect_swap();
        vs_edge();
        wait_swap("drop");
        total++;
        if ({frame_busy, run_clear} !== 2'b00) $display("FAIL drop_to_idle: got busy/rc %b want 00", {frame_busy, run_clear});
        else passed++;
        vs_edge();
        tick();
        total++;
        if (frame_busy !== 1'b0) $display("FAIL idle_ignores_vs: got FRAME_BUSY %b want 0", frame_busy);
        else passed++;
    endtask

    task automatic test_wrap();
        enable = 1'b1;
        tick();
        vs_edge();
        for (int i = 0; i < 251; i++) begin
            pulse_clear_done();
            pulse_queue_done();
            expect_swap();
            vs_edge();
            wait_swap("wrap");
        end
        total++;
        if ({draw_buf, frame_count} !== 9'd0)
            $display("FAIL wrap_256: got db/fc %b/%0d want 0/0", draw_buf, frame_count);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        logic [17:0] obs;
        pulse_clear_done();
        total++;
        if (run_queue !== 1'b1) $display("FAIL rst_in_queue: got RUN_QUEUE %b want 1", run_queue);
        else passed++;
        #2 rst_l = 1'b0;
        #1;
        obs = {run_clear, run_queue, swap_buf, frame_busy, overrun, timeout, draw_buf, stop_address, frame_count};
        total++;
        if (obs !== 18'd0) $display("FAIL rst_async_values: got %h want %h", obs, 18'd0);
        else passed++;
        exp_fc = 8'd0;
        exp_db = 1'b0;
        enable = 1'b0;
        #2 rst_l = 1'b1;
        tick(); tick();
        vs_edge();
        tick();
        total++;
        if (frame_busy !== 1'b0) $display("FAIL rst_needs_enable: got FRAME_BUSY %b want 0", frame_busy);
        else passed++;
        enable = 1'b1;
        sprite_count = 3'd7;
        tick();
        vs_edge();
        total++;
        if ({run_clear, stop_address} !== {1'b1, 3'd7})
            $display("FAIL rst_resume: got rc/stop %b/%0d want 1/7", run_clear, stop_address);
        else passed++;
        pulse_clear_done();
        pulse_queue_done();
        expect_swap();
        vs_edge();
        wait_swap("resume");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_overrun();
        test_same_cycle_swap();
        test_timeout();
        test_done_at_expiry();
        test_enable_drop();
        test_wrap();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
